// File: rtl/batchnorm_stats_divider.sv
// Purpose: capture the per-channel (sum, sum_sq) stream from the batch-norm accumulator.
//          When done_in rises, compute mean = sum/BATCH_SIZE and var = sum_sq/BATCH_SIZE - mean^2
//          for every channel, using one shared restoring divider.
// Latency: 2*WIDTH+3 en-cycles per channel; the first valid_o comes 2*WIDTH+3 cycles after the start edge.
// Backpressure: none on either side; valid_in while busy is dropped and sets err_overrun.
// Ports: clk, rst_n, en | sum_in, sum_sq_in, channel_in, valid_in, done_in
//        | mean_out, var_out, channel_out, valid_out, busy, done, err_overrun
// Optional feature: define BN_VAR_EPS_EN to add EPSILON (saturating) to every variance.
module batchnorm_stats_divider #(
    parameter int WIDTH      = 16,
    parameter int BATCH_SIZE = 10,
    parameter int CHANNELS   = 16,
    parameter int EPSILON    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] sum_sq_in,
    input  logic [4:0]       channel_in,
    input  logic             valid_in,
    input  logic             done_in,
    output logic [WIDTH-1:0] mean_out,
    output logic [WIDTH-1:0] var_out,
    output logic [4:0]       channel_out,
    output logic             valid_out,
    output logic             busy,
    output logic             done,
    output logic             err_overrun
);
    localparam int CIW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [5:0]       CH_LIM   = 6'(CHANNELS);
    localparam logic [4:0]       CH_LAST  = 5'(CHANNELS - 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH:0]   DIVISOR  = (WIDTH+1)'(BATCH_SIZE);

    typedef enum logic [2:0] {
        S_COLLECT, S_LOAD, S_DIV_MEAN, S_DIV_SQ, S_VAR, S_EMIT, S_OUT_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             done_in_q;
    logic [4:0]       ch_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q;
    logic [WIDTH-1:0] mean_q, ex2_q, var_q;
    logic [WIDTH-1:0] mean_out_q, var_out_q;
    logic [4:0]       chan_out_q;
    logic             valid_out_q, done_q, err_q;
    logic [WIDTH-1:0] sum_st_q [CHANNELS];
    logic [WIDTH-1:0] sq_st_q  [CHANNELS];

    logic             start, cnt_last, ch_ok;
    logic [CIW-1:0]   rd_idx, wr_idx;

    assign start    = (state_q == S_COLLECT) && done_in && !done_in_q;
    assign cnt_last = (cnt_q == CNT_LAST);
    assign ch_ok    = ({1'b0, channel_in} < CH_LIM);
    assign rd_idx   = ch_q[CIW-1:0];
    assign wr_idx   = channel_in[CIW-1:0];

    // Restoring divider step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits.
    logic [WIDTH:0]   shifted, trial;
    logic             fits;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign fits    = (shifted >= DIVISOR);
    assign trial   = shifted - DIVISOR;
    assign rem_nx  = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_nx  = {quo_q[WIDTH-2:0], fits};

    // Variance: mean^2 at full width; a negative difference clamps to 0.
    // When not clamped, mean^2 <= ex2 < 2**WIDTH, so its low half is exact.
    logic [2*WIDTH-1:0] msq;
    logic [WIDTH-1:0]   var_calc, var_fin;
    assign msq      = {{WIDTH{1'b0}}, mean_q} * {{WIDTH{1'b0}}, mean_q};
    assign var_calc = (msq > {{WIDTH{1'b0}}, ex2_q}) ? '0 : (ex2_q - msq[WIDTH-1:0]);
`ifdef BN_VAR_EPS_EN
    logic [WIDTH:0] var_eps;
    assign var_eps = {1'b0, var_calc} + (WIDTH+1)'(EPSILON);
    assign var_fin = var_eps[WIDTH] ? '1 : var_eps[WIDTH-1:0];
`else
    assign var_fin = var_calc;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT:  if (start) state_d = S_LOAD;
            S_LOAD:     state_d = S_DIV_MEAN;
            S_DIV_MEAN: if (cnt_last) state_d = S_DIV_SQ;
            S_DIV_SQ:   if (cnt_last) state_d = S_VAR;
            S_VAR:      state_d = S_EMIT;
            S_EMIT:     state_d = (ch_q == CH_LAST) ? S_OUT_DONE : S_LOAD;
            S_OUT_DONE: state_d = S_COLLECT;
            default:    state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_COLLECT;
            done_in_q   <= 1'b0;
            ch_q        <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            mean_q      <= '0;
            ex2_q       <= '0;
            var_q       <= '0;
            mean_out_q  <= '0;
            var_out_q   <= '0;
            chan_out_q  <= '0;
            valid_out_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                sum_st_q[i] <= '0;
                sq_st_q[i]  <= '0;
            end
        end else if (en) begin
            state_q     <= state_d;
            done_in_q   <= done_in;
            valid_out_q <= (state_q == S_EMIT);
            done_q      <= (state_q == S_OUT_DONE);
            if (valid_in && state_q != S_COLLECT) err_q <= 1'b1;
            case (state_q)
                S_COLLECT: begin
                    if (valid_in && ch_ok) begin
                        sum_st_q[wr_idx] <= sum_in;
                        sq_st_q[wr_idx]  <= sum_sq_in;
                    end
                    if (start) ch_q <= '0;
                end
                S_LOAD: begin
                    quo_q <= sum_st_q[rd_idx];
                    rem_q <= '0;
                    cnt_q <= '0;
                end
                S_DIV_MEAN: begin
                    if (cnt_last) begin
                        // Mean is final; reload the divider with sum_sq.
                        mean_q <= quo_nx;
                        quo_q  <= sq_st_q[rd_idx];
                        rem_q  <= '0;
                        cnt_q  <= '0;
                    end else begin
                        quo_q <= quo_nx;
                        rem_q <= rem_nx;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DIV_SQ: begin
                    if (cnt_last) begin
                        ex2_q <= quo_nx;
                        cnt_q <= '0;
                    end else begin
                        quo_q <= quo_nx;
                        rem_q <= rem_nx;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_VAR: var_q <= var_fin;
                S_EMIT: begin
                    mean_out_q <= mean_q;
                    var_out_q  <= var_q;
                    chan_out_q <= ch_q;
                    if (ch_q != CH_LAST) ch_q <= ch_q + 1'b1;
                end
                S_OUT_DONE: begin
                    // Clear the store so channels not written next batch compute as 0.
                    for (int i = 0; i < CHANNELS; i++) begin
                        sum_st_q[i] <= '0;
                        sq_st_q[i]  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mean_out    = mean_out_q;
    assign var_out     = var_out_q;
    assign channel_out = chan_out_q;
    assign valid_out   = valid_out_q;
    assign done        = done_q;
    assign err_overrun = err_q;
    assign busy        = (state_q != S_COLLECT);
endmodule

// File: tb/tb_batchnorm_stats_divider.sv
module tb_batchnorm_stats_divider;
    localparam int W  = 16;
    localparam int BS = 10;
    localparam int NC = 16;
    localparam int PERIOD = 2 * W + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic [W-1:0]  sum_in = '0, sum_sq_in = '0;
    logic [4:0]    channel_in = '0;
    logic          valid_in = 1'b0, done_in = 1'b0;
    logic [W-1:0]  mean_out, var_out;
    logic [4:0]    channel_out;
    logic          valid_out, busy, done, err_overrun;

    batchnorm_stats_divider #(.WIDTH(W), .BATCH_SIZE(BS), .CHANNELS(NC), .EPSILON(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .sum_in(sum_in), .sum_sq_in(sum_sq_in), .channel_in(channel_in),
        .valid_in(valid_in), .done_in(done_in),
        .mean_out(mean_out), .var_out(var_out), .channel_out(channel_out),
        .valid_out(valid_out), .busy(busy), .done(done), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct { int mean; int vr; int ch; } exp_t;
    exp_t q[$];
    int   m_sum [NC];
    int   m_sq  [NC];
    int   total = 0, bad = 0;
    int   exp_err = 0;
    bit   fresh = 0;
    int   ecnt = 0, last_ecnt = 0, done_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Reference: integer division and the clamp rule, straight from the definition.
    function automatic int ref_var(input int s, input int sq);
        int m, e, v;
        m = s / BS;
        e = sq / BS;
        v = (m * m > e) ? 0 : e - m * m;
`ifdef BN_VAR_EPS_EN
        v = v + 1;
        if (v > 65535) v = 65535;
`endif
        return v;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < NC; c++) begin m_sum[c] = 0; m_sq[c] = 0; end
    endfunction

    // A posedge with en=1 is the only place outputs can change.
    always @(posedge clk) begin
        fresh = en && rst_n;
        if (en && rst_n) ecnt++;
    end

    // Monitor: pops one expectation per valid_out strobe.
    always @(negedge clk) begin
        if (fresh && rst_n) begin
            if (valid_out) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_valid: got ch=%0d want no output", channel_out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("mean", int'(mean_out), e.mean);
                    check("var", int'(var_out), e.vr);
                    check("channel", int'(channel_out), e.ch);
                    check("strobe_spacing", ecnt - last_ecnt, PERIOD);
                    last_ecnt = ecnt;
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic push(input int ch, input int s, input int sq);
        @(negedge clk);
        valid_in = 1'b1; channel_in = 5'(ch); sum_in = W'(s); sum_sq_in = W'(sq);
        if (ch < NC) begin m_sum[ch] = s; m_sq[ch] = sq; end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic start_batch(input bit with_valid, input int ch, input int s, input int sq);
        @(negedge clk);
        en = 1'b1;
        done_in = 1'b1;
        if (with_valid) begin
            valid_in = 1'b1; channel_in = 5'(ch); sum_in = W'(s); sum_sq_in = W'(sq);
            if (ch < NC) begin m_sum[ch] = s; m_sq[ch] = sq; end
        end
        for (int c = 0; c < NC; c++) begin
            exp_t e;
            e.mean = m_sum[c] / BS;
            e.vr   = ref_var(m_sum[c], m_sq[c]);
            e.ch   = c;
            q.push_back(e);
        end
        model_clear();
        @(negedge clk);
        valid_in = 1'b0;
        last_ecnt = ecnt;
    endtask

    task automatic wait_done(input bit toggle_en);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
            @(negedge clk);
            if (toggle_en) en = ($urandom_range(0, 3) != 0);
        end
        en = 1'b1;
        check("done_seen", done_cnt - d0, 1);
        repeat (3) @(negedge clk);
        check("done_once", done_cnt - d0, 1);
        check("all_emitted", q.size(), 0);
        check("idle_busy", int'(busy), 0);
        check("err_overrun", int'(err_overrun), exp_err);
        done_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        done_in = 1'b0;
        valid_in = 1'b0;
        #1;
        check("rst_valid", int'(valid_out), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err_overrun), 0);
        check("rst_mean", int'(mean_out), 0);
        check("rst_var", int'(var_out), 0);
        check("rst_chan", int'(channel_out), 0);
        q.delete();
        model_clear();
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic random_fill(input int n);
        for (int i = 0; i < n; i++)
            push($urandom_range(0, 20), $urandom_range(0, 65535), $urandom_range(0, 65535));
    endtask

    initial begin
        model_clear();
        do_reset();

        // Basic, ignored channel, last write wins, capture in the start cycle.
        push(0, 100, 1200);
        push(3, 57, 400);
        push(20, 999, 999);
        push(5, 1, 1);
        push(5, 30, 100);
        start_batch(1'b1, 7, 70, 500);
        wait_done(1'b0);

        // Clamp and boundary; overrun pulse 5 cycles into the run; back-to-back batch.
        push(1, 50, 200);
        push(2, 65535, 65535);
        start_batch(1'b0, 0, 0, 0);
        repeat (4) @(negedge clk);
        valid_in = 1'b1; channel_in = 5'd9; sum_in = 16'd500; sum_sq_in = 16'd500;
        @(negedge clk);
        valid_in = 1'b0;
        exp_err = 1;
        wait_done(1'b0);

        // Random batches, one with en stalls; err stays sticky.
        for (int b = 0; b < 3; b++) begin
            random_fill(int'($urandom_range(3, 12)));
            start_batch(1'b0, 0, 0, 0);
            wait_done(b == 1);
        end

        // Reset during channel 4 DIV_SQ.
        push(4, 1234, 4321);
        push(6, 600, 36100);
        start_batch(1'b0, 0, 0, 0);
        repeat (4 * PERIOD + 20) @(negedge clk);
        do_reset();
        repeat (60) @(negedge clk);
        check("post_reset_idle", int'(busy), 0);
        random_fill(6);
        start_batch(1'b0, 0, 0, 0);
        wait_done(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
